// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU/memory types for the dual-core memory path.
//   word_t      : 32-bit data/address word
//   ramstate_t  : state reported by the RAM each cycle
//   ERROR_FILL  : word returned to a core whose access ended in ERROR
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam word_t ERROR_FILL = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bus between two cores, the memory arbiter and a single-ported RAM.
//   core side : iREN/iaddr (fetch), dREN/dWEN/daddr/dstore (data),
//               iwait/dwait (stall), iload/dload (read data)
//   ram side  : ramREN/ramWEN/ramaddr/ramstore (command),
//               ramload/ramstate (response)
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (cores + RAM)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic [1:0]      iREN;
    word_t [1:0]     iaddr;
    logic [1:0]      dREN;
    logic [1:0]      dWEN;
    word_t [1:0]     daddr;
    word_t [1:0]     dstore;

    logic [1:0]      iwait;
    logic [1:0]      dwait;
    word_t [1:0]     iload;
    word_t [1:0]     dload;

    logic            ramREN;
    logic            ramWEN;
    word_t           ramaddr;
    word_t           ramstore;
    word_t           ramload;
    ramstate_t       ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational winner select for the memory arbiter.
//   dreq[1:0]  in  : per-core data request (read or write)
//   ireq[1:0]  in  : per-core instruction request
//   rr         in  : core that wins a tie within a class
//   valid      out : some request is pending
//   core       out : winning core
//   dclass     out : 1 = winner is a data request, 0 = instruction
// Any data request beats any instruction request.
// -----------------------------------------------------------------------------
module rr_pick (
    input  logic [1:0] dreq,
    input  logic [1:0] ireq,
    input  logic       rr,
    output logic       valid,
    output logic       core,
    output logic       dclass
);

    // Lone requester wins; with both requesting the rr core wins.
    function automatic logic pick(input logic [1:0] req, input logic tie);
        return (req == 2'b11) ? tie : req[1];
    endfunction

    always_comb begin
        valid  = (|dreq) | (|ireq);
        dclass = |dreq;
        core   = dclass ? pick(dreq, rr) : pick(ireq, rr);
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one RAM port between the instruction and data paths of two cores.
// A winner picked in IDLE is registered, so the RAM sees the request one
// cycle after it appears. The grant lasts until the RAM reports ACCESS or
// ERROR, or until the owner drops its request; the arbiter then always
// passes through IDLE before granting again.
//   CLK            in  : system clock
//   nRST           in  : asynchronous active-low reset
//   bus (slave)        : core request/stall/load ports and RAM command/response
// Parameter RR_INIT: core holding round-robin priority after reset.
// -----------------------------------------------------------------------------
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter logic RR_INIT = 1'b0
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2
    } state_t;

    state_t state, next_state;
    logic   owner, next_owner;
    logic   rr,    next_rr;

    logic   pick_valid, pick_core, pick_dclass;
    logic   done;
    word_t  fill;

    rr_pick u_pick (
        .dreq   (bus.dREN | bus.dWEN),
        .ireq   (bus.iREN),
        .rr     (rr),
        .valid  (pick_valid),
        .core   (pick_core),
        .dclass (pick_dclass)
    );

    // ERROR ends the transfer like ACCESS but hands the core a marker word.
    assign done = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR);
    assign fill = (bus.ramstate == ERROR) ? ERROR_FILL : bus.ramload;

    // NOTE: only control state is reset here; every output is decoded from
    // it, so forcing IDLE is enough to park the whole bus during reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            owner <= 1'b0;
            rr    <= RR_INIT;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state <= next_state;
            owner <= next_owner;
            rr    <= next_rr;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        next_state   = state;
        next_owner   = owner;
        next_rr      = rr;
        bus.iwait    = 2'b11;
        bus.dwait    = 2'b11;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    next_state = pick_dclass ? GRANT_D : GRANT_I;
                    next_owner = pick_core;
                end
            end

            GRANT_D: begin
                bus.ramaddr  = bus.daddr[owner];
                bus.ramstore = bus.dstore[owner];
                if (!(bus.dREN[owner] | bus.dWEN[owner])) begin
                    // Owner withdrew: strobes stay low, rr keeps its value.
                    next_state = IDLE;
                end else begin
                    // Write takes precedence so REN and WEN are never both set.
                    bus.ramWEN = bus.dWEN[owner];
                    bus.ramREN = bus.dREN[owner] & ~bus.dWEN[owner];
                    if (done) begin
                        bus.dwait[owner] = 1'b0;
                        bus.dload[owner] = fill;
                        next_state       = IDLE;
                        next_rr          = ~owner;
                    end
                end
            end

            GRANT_I: begin
                bus.ramaddr = bus.iaddr[owner];
                if (!bus.iREN[owner]) begin
                    next_state = IDLE;
                end else begin
                    bus.ramREN = 1'b1;
                    if (done) begin
                        bus.iwait[owner] = 1'b0;
                        bus.iload[owner] = fill;
                        next_state       = IDLE;
                        next_rr          = ~owner;
                    end
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed testbench for mem_arbiter. Inputs change 1 ns after the rising
// edge; outputs are sampled 1 ns later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   mutex_viol = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.RR_INIT(1'b0)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ramREN and ramWEN must never be high together.
    always @(negedge CLK) begin
        if (bus.ramREN && bus.ramWEN) mutex_viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        nRST         = 1'b0;
        bus.iREN     = '0;
        bus.dREN     = '0;
        bus.dWEN     = '0;
        bus.iaddr[0] = 32'h0000_0400;
        bus.iaddr[1] = 32'h0000_0500;
        bus.daddr[0] = 32'h0000_0100;
        bus.daddr[1] = 32'h0000_0200;
        bus.dstore[0] = 32'h0;
        bus.dstore[1] = 32'h0;
        bus.ramload  = 32'h0;
        bus.ramstate = FREE;

        // ---- reset state ----
        step();
        step();
        check("rst iwait",  32'(bus.iwait),  3);
        check("rst dwait",  32'(bus.dwait),  3);
        check("rst iload0", bus.iload[0],    0);
        check("rst dload1", bus.dload[1],    0);
        check("rst ramREN", 32'(bus.ramREN), 0);
        check("rst ramWEN", 32'(bus.ramWEN), 0);
        check("rst ramaddr", bus.ramaddr,    0);
        nRST = 1'b1;

        // ---- both cores dREN, rr=0: core0 then core1 ----
        step();                                   // cycle 1: requests appear
        bus.dREN = 2'b11;
        settle();
        check("t1 c1 no strobe", 32'(bus.ramREN), 0);
        step();                                   // cycle 2: granted, BUSY
        bus.ramstate = BUSY;
        settle();
        check("t1 c2 ramREN",  32'(bus.ramREN), 1);
        check("t1 c2 ramaddr", bus.ramaddr, 32'h100);
        check("t1 c2 dwait",   32'(bus.dwait), 3);
        step();                                   // cycle 3: BUSY
        settle();
        check("t1 c3 dwait",   32'(bus.dwait), 3);
        step();                                   // cycle 4: ACCESS
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h1111_0000;
        settle();
        check("t1 c4 dwait",   32'(bus.dwait), 2);
        check("t1 c4 dload0",  bus.dload[0], 32'h1111_0000);
        check("t1 c4 dload1",  bus.dload[1], 0);
        step();                                   // IDLE between grants
        bus.ramstate = FREE;
        bus.dREN     = 2'b10;
        settle();
        check("t1 idle ramREN", 32'(bus.ramREN), 0);
        check("t1 idle dwait",  32'(bus.dwait), 3);
        step();
        bus.ramstate = BUSY;
        settle();
        check("t1 core1 ramaddr", bus.ramaddr, 32'h200);
        step();
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h2222_0000;
        settle();
        check("t1 core1 dwait", 32'(bus.dwait), 1);
        check("t1 core1 dload", bus.dload[1], 32'h2222_0000);
        step();
        bus.ramstate = FREE;
        bus.dREN     = 2'b00;

        // ---- core0 iREN vs core1 dWEN: data first ----
        bus.iREN      = 2'b01;
        bus.dWEN      = 2'b10;
        bus.daddr[1]  = 32'h0000_0300;
        bus.dstore[1] = 32'hCAFE_0001;
        step();
        bus.ramstate = ACCESS;
        settle();
        check("t2 wr ramWEN",   32'(bus.ramWEN), 1);
        check("t2 wr ramREN",   32'(bus.ramREN), 0);
        check("t2 wr ramaddr",  bus.ramaddr, 32'h300);
        check("t2 wr ramstore", bus.ramstore, 32'hCAFE_0001);
        check("t2 wr dwait",    32'(bus.dwait), 1);
        check("t2 wr iwait",    32'(bus.iwait), 3);
        step();
        bus.dWEN     = 2'b00;
        bus.ramstate = FREE;
        settle();
        check("t2 idle ramREN", 32'(bus.ramREN), 0);
        step();
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h1234_5678;
        settle();
        check("t2 if ramREN",   32'(bus.ramREN), 1);
        check("t2 if ramWEN",   32'(bus.ramWEN), 0);
        check("t2 if ramaddr",  bus.ramaddr, 32'h400);
        check("t2 if ramstore", bus.ramstore, 0);
        check("t2 if iwait",    32'(bus.iwait), 2);
        check("t2 if iload0",   bus.iload[0], 32'h1234_5678);
        step();
        bus.iREN     = 2'b00;
        bus.ramstate = FREE;

        // ---- instruction tie with rr=1: core1 wins ----
        bus.iREN = 2'b11;
        step();
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h0BAD_F00D;
        settle();
        check("t3 tie ramaddr", bus.ramaddr, 32'h500);
        check("t3 tie iwait",   32'(bus.iwait), 1);
        step();
        bus.iREN     = 2'b00;
        bus.ramstate = FREE;

        // ---- core1 dREN+dWEN: write wins ----
        bus.dREN      = 2'b10;
        bus.dWEN      = 2'b10;
        bus.daddr[1]  = 32'h0000_0040;
        bus.dstore[1] = 32'hDEAD_BEEF;
        step();
        bus.ramstate = BUSY;
        settle();
        check("t4 rw ramWEN",   32'(bus.ramWEN), 1);
        check("t4 rw ramREN",   32'(bus.ramREN), 0);
        check("t4 rw ramaddr",  bus.ramaddr, 32'h40);
        check("t4 rw ramstore", bus.ramstore, 32'hDEAD_BEEF);
        step();
        bus.ramstate = ACCESS;
        settle();
        check("t4 rw dwait", 32'(bus.dwait), 1);
        step();
        bus.dREN     = 2'b00;
        bus.dWEN     = 2'b00;
        bus.ramstate = FREE;

        // ---- ERROR on core0 fetch ----
        bus.iREN     = 2'b01;
        bus.iaddr[0] = 32'h0000_0080;
        step();
        bus.ramstate = ERROR;
        bus.ramload  = 32'h5555_5555;
        settle();
        check("t5 err iwait",  32'(bus.iwait), 2);
        check("t5 err iload0", bus.iload[0], 32'hBAD1_BAD1);
        check("t5 err iload1", bus.iload[1], 0);
        step();
        bus.ramstate = FREE;
        settle();
        check("t5 err after iwait", 32'(bus.iwait), 3);
        bus.iREN = 2'b00;

        // ---- core1 aborts during BUSY (rr=1 before and after) ----
        bus.dREN     = 2'b10;
        bus.daddr[1] = 32'h0000_0600;
        step();
        bus.ramstate = BUSY;
        settle();
        check("t6 busy ramREN", 32'(bus.ramREN), 1);
        step();
        bus.dREN = 2'b00;
        settle();
        check("t6 abort ramREN", 32'(bus.ramREN), 0);
        check("t6 abort ramWEN", 32'(bus.ramWEN), 0);
        check("t6 abort dwait",  32'(bus.dwait), 3);
        step();
        bus.ramstate = FREE;
        bus.daddr[1] = 32'h0000_0200;
        bus.dREN     = 2'b11;
        settle();
        check("t6 idle ramREN", 32'(bus.ramREN), 0);
        step();
        bus.ramstate = BUSY;
        settle();
        check("t6 rr kept ramaddr", bus.ramaddr, 32'h200);

        // ---- reset pulse mid-GRANT_D ----
        nRST = 1'b0;
        settle();
        check("t7 rst dwait",  32'(bus.dwait), 3);
        check("t7 rst ramREN", 32'(bus.ramREN), 0);
        check("t7 rst ramWEN", 32'(bus.ramWEN), 0);
        step();
        nRST = 1'b1;
        settle();
        check("t7 release ramREN", 32'(bus.ramREN), 0);
        check("t7 release dwait",  32'(bus.dwait), 3);
        step();
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h7777_7777;
        settle();
        check("t7 rr init ramaddr", bus.ramaddr, 32'h100);
        check("t7 rr init dwait",   32'(bus.dwait), 2);
        step();
        bus.dREN     = 2'b00;
        bus.ramstate = FREE;
        step();

        check("ren wen mutex", mutex_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
